mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified single-port instruction/data memory between the fetch stage (IF port) and the load/store path (DM port) of the RV32I core.
- Sits between the fetch/memory stages and the memory model.
- Serialises accesses with one outstanding transaction, gives data priority, and guarantees fetch forward progress through a streak limiter.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
MAX_DM_STREAK, 4, consecutive DM grants allowed while IF waits (must be at least 1)

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  AWIDTH  fetch address
if_gnt  out  1  one-cycle pulse: IF request captured
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DWIDTH  fetched instruction
dm_req  in  1  data request; held with dm_we, dm_addr, dm_wdata stable until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AWIDTH  data address
dm_wdata  in  DWIDTH  store data
dm_gnt  out  1  one-cycle pulse: DM request captured
dm_rvalid  out  1  one-cycle pulse: load data valid or store complete
dm_rdata  out  DWIDTH  load data (0 for stores)
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  AWIDTH  memory address
mem_wdata  out  DWIDTH  memory write data
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  memory response valid (reads and writes)
mem_rdata  in  DWIDTH  memory read data
stat_if_grants  out  32  IF grant count (optional feature)
stat_dm_grants  out  32  DM grant count (optional feature)
stat_stall_cycles  out  32  stall cycle count (optional feature)

Behaviour:
- Reset: state IDLE, streak=0, owner=NONE. All outputs 0, including mem_* and stat_*.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - dm_req alone: DM wins.
  - if_req alone: IF wins.
  - Both asserted: DM wins unless streak==MAX_DM_STREAK, in which case IF wins.
- IDLE, on a win:
  - Pulse the winner's gnt in the same cycle.
  - Register addr/we/wdata; IF is forced to we=0.
  - Record owner; go to ISSUE.
  - No request: stay in IDLE.
- Streak counter:
  - DM grant while if_req is high: streak+1, saturating at MAX_DM_STREAK.
  - Any IF grant: streak=0.
  - DM grant with if_req low: streak=0.
- ISSUE:
  - mem_req=1 with the registered fields.
  - mem_ready=0: hold all fields.
  - mem_ready=1: go to WAIT.
  - mem_ready=1 and mem_rvalid=1 in the same cycle: complete immediately (as in WAIT) and go to IDLE.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: pulse owner_rvalid in the same cycle, owner_rdata=mem_rdata (dm_rdata=0 if the access is a store), go to IDLE.
- mem_rvalid outside WAIT/ISSUE-completion is ignored.
- The non-owner's rvalid stays 0; its rdata is 0.
- Minimum latency, request to rvalid: 2 cycles.
  - Cycle 0: gnt.
  - Cycle 1: ISSUE with ready and rvalid both high.
- The next grant can occur the cycle after rvalid.
- Requests asserted during ISSUE/WAIT wait; no gnt is given. Requesters must not drop req before gnt.
- Reset mid-transaction: return to IDLE and drop the transaction. A late mem_rvalid is ignored.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - stat_if_grants and stat_dm_grants increment on each respective gnt pulse.
  - stat_stall_cycles increments each cycle where (if_req or dm_req) is high and no gnt is issued.
  - All three counters wrap at 2^32 and are cleared by reset.
- Not defined: stat_* ports are still present and tied to 0; no counter flops are built.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_e {IDLE, ISSUE, WAIT}
  - arb_owner_e {NONE, OWN_IF, OWN_DM}
  - STAT_W=32
- Sub-module mem_arb_pick: combinational picker with inputs if_req, dm_req, streak_full and output a winner of type arb_owner_e. It is reused for priority unit tests.

Test Plan:
1. Only if_req, if_addr=0x01000000; memory ready at once, rvalid with rdata=0x00000013 -> if_gnt in cycle 0, mem_addr=0x01000000 and mem_we=0 in cycle 1, if_rvalid with if_rdata=0x00000013 in cycle 1.
2. if_req and dm_req (load, 0x01000100) rise together, streak=0 -> dm_gnt first; IF is granted the cycle after dm_rvalid.
3. dm_req held continuously and if_req held, MAX_DM_STREAK=4 -> exactly 4 DM grants, then 1 IF grant, then streak=0 and DM wins again.
4. Store dm_we=1, dm_addr=0x01000200, dm_wdata=0xDEADBEEF; mem_ready low for 3 cycles -> mem_req/addr/wdata stable for those 3 cycles; dm_rvalid=1 with dm_rdata=0.
5. reset pulsed in WAIT, then mem_rvalid=1 the next cycle -> no if_rvalid/dm_rvalid, state IDLE, all outputs 0.
6. With MEM_ARB_STATS_EN, 2 IF and 3 DM transactions with 1 contended cycle -> stat_if_grants=2, stat_dm_grants=3, stat_stall_cycles equals the count of req-high/no-gnt cycles; without the macro all stat_* read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
  typedef enum logic [1:0] {NONE, OWN_IF, OWN_DM} arb_owner_e;
  localparam int STAT_W = 32;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational IF/DM priority picker: data wins unless the DM streak is exhausted.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       streak_full,
  output arb_owner_e winner
);
  always_comb begin
    winner = NONE;
    if (dm_req && !(if_req && streak_full)) winner = OWN_DM;
    else if (if_req)                        winner = OWN_IF;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (IF) and load/store (DM).
// Define MEM_ARB_STATS_EN to build the grant/stall statistics counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH        = 32,
  parameter int DWIDTH        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AWIDTH-1:0] dm_addr,
  input  logic [DWIDTH-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DWIDTH-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_if_grants,
  output logic [STAT_W-1:0] stat_dm_grants,
  output logic [STAT_W-1:0] stat_stall_cycles
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  arb_state_e    state;
  arb_owner_e    owner;
  arb_owner_e    winner;
  logic [SW-1:0] streak;
  logic          own_we;
  logic          streak_full;
  logic          grant_ok;
  logic          done;

  assign streak_full = (streak == SW'(MAX_DM_STREAK));

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .streak_full (streak_full),
    .winner      (winner)
  );

  // Grants and responses are same-cycle handshakes, masked while reset is held.
  assign grant_ok  = !reset && (state == IDLE);
  assign if_gnt    = grant_ok && (winner == OWN_IF);
  assign dm_gnt    = grant_ok && (winner == OWN_DM);
  assign done      = !reset && mem_rvalid &&
                     ((state == WAIT) || ((state == ISSUE) && mem_ready));
  assign if_rvalid = done && (owner == OWN_IF);
  assign dm_rvalid = done && (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = (dm_rvalid && !own_we) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= NONE;
      streak    <= '0;
      own_we    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winner == OWN_IF) begin
            state     <= ISSUE;
            owner     <= OWN_IF;
            streak    <= '0;
            own_we    <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (winner == OWN_DM) begin
            state     <= ISSUE;
            owner     <= OWN_DM;
            own_we    <= dm_we;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // Streak only grows while fetch is actually being held off.
            if (!if_req)          streak <= '0;
            else if (!streak_full) streak <= streak + SW'(1);
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (mem_rvalid) begin
              state <= IDLE;
              owner <= NONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
            owner <= NONE;
          end
        end
        default: begin
          state <= IDLE;
          owner <= NONE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] if_cnt, dm_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      if_cnt    <= '0;
      dm_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (if_gnt) if_cnt <= if_cnt + STAT_W'(1);
      if (dm_gnt) dm_cnt <= dm_cnt + STAT_W'(1);
      if ((if_req || dm_req) && !(if_gnt || dm_gnt)) stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end

  assign stat_if_grants    = if_cnt;
  assign stat_dm_grants    = dm_cnt;
  assign stat_stall_cycles = stall_cnt;
`else
  assign stat_if_grants    = '0;
  assign stat_dm_grants    = '0;
  assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expectations, monitors pop and compare.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stat_if_grants, stat_dm_grants, stat_stall_cycles;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_DM_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants),
    .stat_stall_cycles(stat_stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [133:0] outs;
  assign outs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                 mem_req, mem_we, mem_addr, mem_wdata};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: programmable ready latency, same-cycle or next-cycle response.
  logic [31:0] mem [logic [31:0]];
  int   ready_lat = 0;
  int   wait_cnt  = 0;
  bit   fast      = 1'b1;
  bit   rv_hold   = 1'b0;
  bit   inject    = 1'b0;
  bit   pending   = 1'b0;
  logic [31:0] pend_data;

  always @(posedge clk) begin
    #2;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    if (inject) begin
      inject = 1'b0; pending = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    end else if (pending) begin
      if (!rv_hold) begin
        pending = 1'b0; mem_rvalid = 1'b1; mem_rdata = pend_data;
      end
    end else if (mem_req === 1'b1) begin
      if (wait_cnt < ready_lat) wait_cnt++;
      else begin
        wait_cnt  = 0;
        mem_ready = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          pend_data = 32'hBAD0BAD0;
        end else begin
          pend_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'hFFFFFFFF;
        end
        if (fast) begin mem_rvalid = 1'b1; mem_rdata = pend_data; end
        else pending = 1'b1;
      end
    end
  end

  // Scoreboard queues
  byte         gq[$];
  logic [64:0] mq[$];
  logic [31:0] iq[$], dq[$];
  int last_if_gnt, last_dm_gnt, last_if_rv, last_dm_rv;
  int hold_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (if_gnt && dm_gnt) chk("gnt_both", 1, 0);
      if (if_gnt || dm_gnt) begin
        if (if_gnt) last_if_gnt = cyc; else last_dm_gnt = cyc;
        if (gq.size() == 0) chk("gnt_unexpected", {7'd0, if_gnt}, 8'hFF);
        else chk("gnt_order", (if_gnt ? 8'h49 : 8'h44), gq.pop_front());
      end
      if (mem_req) begin
        if (mq.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          chk("mem_fields", {mem_we, mem_addr, mem_wdata}, mq[0]);
          if (mem_ready) mq.delete(0);
          else hold_cyc++;
        end
      end
      if (if_rvalid) begin
        last_if_rv = cyc;
        chk("if_rv_nonowner_dm", {dm_rvalid, dm_rdata}, 0);
        if (iq.size() == 0) chk("if_rvalid_unexpected", 1, 0);
        else chk("if_rdata", if_rdata, iq.pop_front());
      end
      if (dm_rvalid) begin
        last_dm_rv = cyc;
        chk("dm_rv_nonowner_if", {if_rvalid, if_rdata}, 0);
        if (dq.size() == 0) chk("dm_rvalid_unexpected", 1, 0);
        else chk("dm_rdata", dm_rdata, dq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_if(input logic [31:0] a, input logic [31:0] d, input bit has_rv);
    gq.push_back(8'h49);
    mq.push_back({1'b0, a, 32'h0});
    if (has_rv) iq.push_back(d);
  endtask

  task automatic exp_dm(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    gq.push_back(8'h44);
    mq.push_back({we, a, wd});
    dq.push_back(rd);
  endtask

  task automatic if_op(input logic [31:0] a, input bit keep);
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_gnt) begin
        tick();
        if (!keep) if_req = 1'b0;
        return;
      end
      tick();
    end
    chk("if_gnt_timeout", 0, 1);
    if_req = 1'b0;
  endtask

  task automatic dm_op(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit keep);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm_gnt) begin
        tick();
        if (!keep) dm_req = 1'b0;
        return;
      end
      tick();
    end
    chk("dm_gnt_timeout", 0, 1);
    dm_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h01000000] = 32'h00000013;
    mem[32'h01000004] = 32'h00100113;
    mem[32'h01000100] = 32'h00A00093;
    mem[32'h01000104] = 32'h11111111;
    mem[32'h01000108] = 32'h22222222;
    mem[32'h0100010C] = 32'h33333333;
    mem[32'h01000110] = 32'h44444444;
    mem[32'h01000114] = 32'h55555555;
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h01000000;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state: everything low even with a request pending
    repeat (2) tick();
    @(negedge clk);
    chk("reset_outputs", outs, 0);
    chk("reset_stats", {stat_if_grants, stat_dm_grants, stat_stall_cycles}, 0);
    tick();
    if_req = 1'b0; reset = 1'b0;
    tick();

    // T1: lone fetch, minimum latency
    exp_if(32'h01000000, 32'h00000013, 1);
    if_op(32'h01000000, 0);
    tick(); tick();
    chk("t1_latency", last_if_rv - last_if_gnt, 1);

    // T2: simultaneous requests, DM first, IF the cycle after dm_rvalid
    exp_dm(0, 32'h01000100, 0, 32'h00A00093);
    exp_if(32'h01000004, 32'h00100113, 1);
    fork
      if_op(32'h01000004, 0);
      dm_op(0, 32'h01000100, 0, 0);
    join
    tick(); tick();
    chk("t2_if_after_dm_rv", last_if_gnt - last_dm_rv, 1);

    // T3: streak limiter, 4 DM then IF then DM again
    exp_dm(0, 32'h01000104, 0, 32'h11111111);
    exp_dm(0, 32'h01000108, 0, 32'h22222222);
    exp_dm(0, 32'h0100010C, 0, 32'h33333333);
    exp_dm(0, 32'h01000110, 0, 32'h44444444);
    exp_if(32'h01000000, 32'h00000013, 1);
    exp_dm(0, 32'h01000114, 0, 32'h55555555);
    exp_dm(0, 32'h01000100, 0, 32'h00A00093);
    fork
      if_op(32'h01000000, 0);
      begin
        dm_op(0, 32'h01000104, 0, 1);
        dm_op(0, 32'h01000108, 0, 1);
        dm_op(0, 32'h0100010C, 0, 1);
        dm_op(0, 32'h01000110, 0, 1);
        dm_op(0, 32'h01000114, 0, 1);
        dm_op(0, 32'h01000100, 0, 0);
      end
    join
    tick(); tick();
    // streak is back to 0: contention goes to DM again
    exp_dm(0, 32'h01000108, 0, 32'h22222222);
    exp_if(32'h01000004, 32'h00100113, 1);
    fork
      if_op(32'h01000004, 0);
      dm_op(0, 32'h01000108, 0, 0);
    join
    tick(); tick();

    // T4: store with mem_ready held low for 3 cycles
    ready_lat = 3; hold_cyc = 0;
    exp_dm(1, 32'h01000200, 32'hDEADBEEF, 0);
    dm_op(1, 32'h01000200, 32'hDEADBEEF, 0);
    repeat (5) tick();
    ready_lat = 0;
    chk("t4_hold_cycles", hold_cyc, 3);

    // T5: reset in WAIT, then a late mem_rvalid that must be ignored
    fast = 1'b0; rv_hold = 1'b1;
    exp_if(32'h01000000, 0, 0);
    if_op(32'h01000000, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; inject = 1'b1;
    @(negedge clk);
    chk("t5_outputs_after_reset", outs, 0);
    chk("t5_stats_cleared", {stat_if_grants, stat_dm_grants, stat_stall_cycles}, 0);
    tick();
    fast = 1'b1; rv_hold = 1'b0;

    // T6: 2 IF + 3 DM with one stalled cycle
    exp_dm(0, 32'h01000104, 0, 32'h11111111);
    exp_if(32'h01000000, 32'h00000013, 1);
    fork
      if_op(32'h01000000, 0);
      dm_op(0, 32'h01000104, 0, 0);
    join
    tick();
    exp_dm(1, 32'h01000300, 32'h0BADF00D, 0);
    dm_op(1, 32'h01000300, 32'h0BADF00D, 0);
    tick();
    exp_dm(0, 32'h01000200, 0, 32'hDEADBEEF);
    dm_op(0, 32'h01000200, 0, 0);
    tick();
    exp_if(32'h01000004, 32'h00100113, 1);
    if_op(32'h01000004, 0);
    tick(); tick();
    @(negedge clk);
`ifdef MEM_ARB_STATS_EN
    chk("t6_stat_if", stat_if_grants, 2);
    chk("t6_stat_dm", stat_dm_grants, 3);
    chk("t6_stat_stall", stat_stall_cycles, 1);
`else
    chk("t6_stat_if", stat_if_grants, 0);
    chk("t6_stat_dm", stat_dm_grants, 0);
    chk("t6_stat_stall", stat_stall_cycles, 0);
`endif

    chk("queues_drained", gq.size() + mq.size() + iq.size() + dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
